image_ram_reader: RTL

IMAGE_RAM_READER -- requirements
Module: image_ram_reader

---
 rtl/image_ram_reader_if.sv | 31 +++
 rtl/image_ram_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/image_ram_reader_if.sv
// Frame RAM read port and packed-pixel byte stream of the image RAM reader.
// The master side is the reader; the slave side is the RAM plus the byte sink.
interface image_ram_reader_if;
  logic [31:0] address;
  logic [31:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_eol;
  logic        out_last;

  modport master (
    output address,
    input  rdata,
    output out_data,
    output out_valid,
    output out_eol,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  address,
    output rdata,
    input  out_data,
    input  out_valid,
    input  out_eol,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/image_ram_reader.sv
// Streams a 1-bit-per-pixel frame RAM out as packed bytes (first pixel in bit 7),
// with row and frame markers, backpressure, abort and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; address parked at 0
// READ  | one pixel captured per cycle into the pack register
// EMIT  | packed byte offered downstream, held until out_ready
// DONE  | one-cycle done pulse after the final byte
module image_ram_reader #(
  parameter int DEPTH   = 57600,
  parameter int ROW_PIX = 240
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  image_ram_reader_if.master  bus
);

  localparam int BYTES     = DEPTH / 8;
  localparam int ROW_BYTES = ROW_PIX / 8;
  localparam int BW        = $clog2(BYTES + 1);
  localparam int CW        = $clog2(ROW_BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     address_q, address_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [7:0]      pack_q, pack_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_eol_q, out_eol_d;
  logic            out_last_q, out_last_d;
  logic [7:0]      pack_next;
  logic            rdata_unused;

  // Only bit 0 of the RAM word carries the pixel.
  assign rdata_unused = ^bus.rdata[31:1];
  assign pack_next    = {pack_q[6:0], bus.rdata[0]};

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    col_cnt_d   = col_cnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_eol_d   = out_eol_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        address_d   = '0;
        out_valid_d = 1'b0;
        out_eol_d   = 1'b0;
        out_last_d  = 1'b0;
        if (start && !abort) begin
          state_d    = READ;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          col_cnt_d  = '0;
          pack_d     = '0;
        end
      end
      READ: begin
        pack_d    = pack_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        // The final pixel sits at DEPTH-1; park there instead of running past the frame.
        if (address_q != 32'(DEPTH - 1)) begin
          address_d = address_q + 32'd1;
        end
        if (bit_cnt_q == 3'd7) begin
          state_d     = EMIT;
          out_data_d  = pack_next;
          out_valid_d = 1'b1;
          out_eol_d   = (col_cnt_q == CW'(ROW_BYTES - 1));
          out_last_d  = (byte_cnt_q == BW'(BYTES - 1));
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_eol_d   = 1'b0;
          out_last_d  = 1'b0;
          byte_cnt_d  = byte_cnt_q + 1'b1;
          col_cnt_d   = (col_cnt_q == CW'(ROW_BYTES - 1)) ? '0 : col_cnt_q + 1'b1;
          state_d     = out_last_q ? DONE : READ;
        end
      end
      DONE: begin
        state_d   = IDLE;
        address_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort drops everything in flight, including a half-packed byte.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      address_d   = '0;
      bit_cnt_d   = '0;
      pack_d      = '0;
      out_valid_d = 1'b0;
      out_eol_d   = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      address_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      col_cnt_q   <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      col_cnt_q   <= col_cnt_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.address   = address_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_last  = out_last_q;

endmodule
